icache_mem_arbiter: RTL and testbench

- Shares one downstream instruction-memory port between NumRequesters instruction caches, e.g. several compute units or per-cluster caches.
- Arbitrates cacheline refill requests round-robin and locks each grant until the downstream handshake completes.
- Records the issuing requester of every in-flight request in an in-order ID FIFO, and routes each response back to that requester one cycle after it arrives.
- Sits between the caches' mem_req/mem_addr/mem_valid/mem_data interfaces and the shared memory/interconnect port.

---
 rtl/icache_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_icache_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_arbiter.sv
// icache_mem_arbiter
//
// Lets several instruction caches share one downstream instruction-memory
// port. Refill requests are arbitrated round-robin. A grant stays locked
// while downstream stalls. The requester behind every accepted request is
// kept in an in-order ID FIFO, so each response can be routed back to its
// requester one cycle after it arrives.
//
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset
//   req_valid_i    per-cache refill request valid
//   req_ready_o    per-cache request accepted (one-hot or zero)
//   req_addr_i     per-cache cacheline address, flattened (requester i at slice i)
//   rsp_valid_o    one-hot response pulse
//   rsp_data_o     response cacheline, broadcast to all caches
//   mem_req_o      downstream request valid
//   mem_addr_o     downstream cacheline address
//   mem_ready_i    downstream request ready
//   mem_valid_i    downstream response valid (cannot be backpressured)
//   mem_data_i     downstream response cacheline
module icache_mem_arbiter #(
  parameter int NumRequesters      = 4,
  parameter int CachelineAddrWidth = 31,
  parameter int CachelineIdxBits   = 1,
  parameter int EncInstWidth       = 32,
  parameter int MaxOutstanding     = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NumRequesters-1:0]                      req_valid_i,
  output logic [NumRequesters-1:0]                      req_ready_o,
  input  logic [NumRequesters*CachelineAddrWidth-1:0]   req_addr_i,
  output logic [NumRequesters-1:0]                      rsp_valid_o,
  output logic [(1<<CachelineIdxBits)*EncInstWidth-1:0] rsp_data_o,
  output logic                                          mem_req_o,
  output logic [CachelineAddrWidth-1:0]                 mem_addr_o,
  input  logic                                          mem_ready_i,
  input  logic                                          mem_valid_i,
  input  logic [(1<<CachelineIdxBits)*EncInstWidth-1:0] mem_data_i
);

  localparam int ReqIdWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int LineWidth  = (1 << CachelineIdxBits) * EncInstWidth;
  localparam int PtrWidth   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntWidth   = $clog2(MaxOutstanding + 1);

  logic [ReqIdWidth-1:0]    rr_q, rr_d;
  logic                     lock_q, lock_d;
  logic [ReqIdWidth-1:0]    lock_id_q, lock_id_d;
  logic [NumRequesters-1:0] busy_q, busy_d;
  logic [PtrWidth-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]      count_q, count_d;
  logic [ReqIdWidth-1:0]    fifo_q [MaxOutstanding];
  logic [NumRequesters-1:0] rsp_valid_q, rsp_valid_d;
  logic [LineWidth-1:0]     rsp_data_q;

  logic [NumRequesters-1:0] eligible;
  logic                     grant_valid;
  logic [ReqIdWidth-1:0]    grant_id;
  logic                     push, pop;
  logic [ReqIdWidth-1:0]    head_id;

  assign eligible = req_valid_i & ~busy_q;
  assign head_id  = fifo_q[rd_ptr_q];
  assign pop      = mem_valid_i && (count_q != '0);

  // Grant selection. The search walks offsets from the highest down so the
  // last hit (lowest offset from rr_q) wins. A locked grant overrides it.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (lock_q) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else begin
      for (int k = NumRequesters - 1; k >= 0; k--) begin
        idx = (int'(rr_q) + k) % NumRequesters;
        if (eligible[idx]) begin
          grant_valid = 1'b1;
          grant_id    = ReqIdWidth'(idx);
        end
      end
    end
  end

  // A full ID FIFO stalls new requests. A pop in the same cycle only
  // frees the slot for the following cycle.
  always_comb begin
    mem_req_o   = grant_valid && (count_q < CntWidth'(MaxOutstanding));
    mem_addr_o  = '0;
    req_ready_o = '0;
    if (mem_req_o) begin
      mem_addr_o = req_addr_i[int'(grant_id)*CachelineAddrWidth +: CachelineAddrWidth];
    end
    if (mem_req_o && mem_ready_i) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  assign push = mem_req_o && mem_ready_i;

  // Next-state logic for the arbitration state, busy flags and FIFO pointers.
  always_comb begin
    rr_d        = rr_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    busy_d      = busy_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = '0;
    if (mem_req_o && !mem_ready_i) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end
    if (push) begin
      busy_d[grant_id] = 1'b1;
      rr_d     = (grant_id == ReqIdWidth'(NumRequesters - 1)) ? '0 : grant_id + 1'b1;
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      busy_d[head_id]      = 1'b0;
      rsp_valid_d[head_id] = 1'b1;
      rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers. The response data register only loads on a pop so it
  // holds its last value between pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      busy_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      if (pop) begin
        rsp_data_q <= mem_data_i;
      end
    end
  end

  // ID storage needs no reset; only entries between the pointers are read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= grant_id;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

`ifndef SYNTHESIS
  logic [7:0]                    since_rst_q;
  logic                          prev_stall_q;
  logic [CachelineAddrWidth-1:0] prev_addr_q;

  // A response into an empty FIFO is only legitimate shortly after a reset
  // discarded the in-flight IDs.
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      since_rst_q <= '0;
    end else if (since_rst_q != 8'hFF) begin
      since_rst_q <= since_rst_q + 8'd1;
    end
    prev_stall_q <= rst_ni && mem_req_o && !mem_ready_i;
    prev_addr_q  <= mem_addr_o;
    if (rst_ni) begin
      assert ($onehot0(req_ready_o)) else $error("req_ready_o not one-hot");
      assert ($onehot0(rsp_valid_o)) else $error("rsp_valid_o not one-hot");
      assert (int'(count_q) <= MaxOutstanding) else $error("ID FIFO overflow");
      if (prev_stall_q) begin
        assert (mem_addr_o == prev_addr_q) else $error("mem_addr_o changed while stalled");
      end
      if (mem_valid_i && count_q == '0) begin
        assert (int'(since_rst_q) < MaxOutstanding + 2) else $error("response with no request in flight");
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed testbench for icache_mem_arbiter with four requesters and a
// two-entry ID FIFO, so the full-FIFO stall is easy to reach.
module tb_icache_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 31;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_ready_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]  rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ready_i;
  logic          mem_valid_i;
  logic [DW-1:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  icache_mem_arbiter #(
    .NumRequesters(N), .CachelineAddrWidth(AW), .CachelineIdxBits(1),
    .EncInstWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs are driven and outputs sampled just after the falling edge.
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic setAddr(input int i, input logic [AW-1:0] a);
    req_addr_i[i*AW +: AW] = a;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
    step();
    step();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_addr_i = '0;
    doReset();
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b expected 0000", rsp_valid_o); end
    checks++; if (rsp_data_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h expected 0", rsp_data_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b expected 0", mem_req_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got %b expected 0000", req_ready_o); end
    checks++; if (mem_addr_o !== 31'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h expected 0", mem_addr_o); end
  endtask

  task automatic test_single_request();
    doReset();
    setAddr(2, 31'h1234);
    req_valid_i = 4'b0100;
    mem_ready_i = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL single_mem_req got %b expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 31'h1234) begin errors++; $display("[TB] FAIL single_mem_addr got %h expected 1234", mem_addr_o); end
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("[TB] FAIL single_req_ready got %b expected 0100", req_ready_o); end
    step();
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    #1;
    checks++; if (dut.busy_q !== 4'b0100) begin errors++; $display("[TB] FAIL single_busy_set got %b expected 0100", dut.busy_q); end
    step();
    step();
    mem_valid_i = 1'b1;
    mem_data_i  = 64'hDEADBEEF_CAFEF00D;
    step();
    mem_valid_i = 1'b0;
    mem_data_i  = 64'h0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0100) begin errors++; $display("[TB] FAIL single_rsp_valid got %b expected 0100", rsp_valid_o); end
    checks++; if (rsp_data_o !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("[TB] FAIL single_rsp_data got %h expected deadbeefcafef00d", rsp_data_o); end
    step();
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_rsp_pulse got %b expected 0000", rsp_valid_o); end
    checks++; if (rsp_data_o !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("[TB] FAIL single_rsp_hold got %h expected deadbeefcafef00d", rsp_data_o); end
    checks++; if (dut.busy_q !== 4'b0000) begin errors++; $display("[TB] FAIL single_busy_clear got %b expected 0000", dut.busy_q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    doReset();
    for (int i = 0; i < N; i++) setAddr(i, 31'(32'h100 + i));
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      req_valid_i = 4'b1111;
      mem_ready_i = 1'b1;
      #1;
      checks++; if (req_ready_o !== exp) begin errors++; $display("[TB] FAIL rr_grant%0d got %b expected %b", k, req_ready_o, exp); end
      checks++; if (mem_addr_o !== 31'(32'h100 + (k % 4))) begin errors++; $display("[TB] FAIL rr_addr%0d got %h expected %h", k, mem_addr_o, 32'h100 + (k % 4)); end
      step();
      req_valid_i = '0;
      mem_ready_i = 1'b0;
      mem_valid_i = 1'b1;
      mem_data_i  = 64'h1111_0000_0000_0000 + 64'(k);
      #1;
      if (k == 0) begin
        checks++; if (dut.rr_q !== 2'd1) begin errors++; $display("[TB] FAIL rr_ptr_after_first got %0d expected 1", dut.rr_q); end
      end
      step();
      mem_valid_i = 1'b0;
      #1;
      checks++; if (rsp_valid_o !== exp) begin errors++; $display("[TB] FAIL rr_rsp%0d got %b expected %b", k, rsp_valid_o, exp); end
      checks++; if (rsp_data_o !== 64'h1111_0000_0000_0000 + 64'(k)) begin errors++; $display("[TB] FAIL rr_data%0d got %h expected %h", k, rsp_data_o, 64'h1111_0000_0000_0000 + 64'(k)); end
    end
  endtask

  task automatic test_lock();
    doReset();
    setAddr(3, 31'h3333);
    setAddr(0, 31'h0AAA);
    req_valid_i = 4'b1000;
    mem_ready_i = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 31'h3333) begin errors++; $display("[TB] FAIL lock_first req=%b addr=%h expected req=1 addr=3333", mem_req_o, mem_addr_o); end
    for (int c = 1; c < 5; c++) begin
      step();
      req_valid_i = 4'b1001;
      #1;
      checks++; if (mem_addr_o !== 31'h3333) begin errors++; $display("[TB] FAIL lock_hold%0d got %h expected 3333", c, mem_addr_o); end
      checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL lock_noready%0d got %b expected 0000", c, req_ready_o); end
    end
    step();
    mem_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b1000 || mem_addr_o !== 31'h3333) begin errors++; $display("[TB] FAIL lock_accept ready=%b addr=%h expected 1000/3333", req_ready_o, mem_addr_o); end
    step();
    req_valid_i = 4'b0001;
    #1;
    checks++; if (req_ready_o !== 4'b0001 || mem_addr_o !== 31'h0AAA) begin errors++; $display("[TB] FAIL lock_next ready=%b addr=%h expected 0001/0aaa", req_ready_o, mem_addr_o); end
    step();
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b1;
    step();
    checks++; if (rsp_valid_o !== 4'b1000) begin errors++; $display("[TB] FAIL lock_rsp3 got %b expected 1000", rsp_valid_o); end
    step();
    mem_valid_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL lock_rsp0 got %b expected 0001", rsp_valid_o); end
  endtask

  task automatic test_full_fifo();
    doReset();
    for (int i = 0; i < N; i++) setAddr(i, 31'(32'h10 + i));
    req_valid_i = 4'b0111;
    mem_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL full_acc0 got %b expected 0001", req_ready_o); end
    step();
    req_valid_i = 4'b0110;
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL full_acc1 got %b expected 0010", req_ready_o); end
    step();
    req_valid_i = 4'b0100;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL full_stall got %b expected 0", mem_req_o); end
    checks++; if (dut.count_q !== 2'd2) begin errors++; $display("[TB] FAIL full_count got %0d expected 2", dut.count_q); end
    step();
    mem_valid_i = 1'b1;
    mem_data_i  = 64'hF0F0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL full_no_bypass got %b expected 0", mem_req_o); end
    step();
    mem_valid_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0001) begin errors++; $display("[TB] FAIL full_rsp0 got %b expected 0001", rsp_valid_o); end
    checks++; if (mem_req_o !== 1'b1 || req_ready_o !== 4'b0100 || mem_addr_o !== 31'h12) begin errors++; $display("[TB] FAIL full_resume req=%b ready=%b addr=%h expected 1/0100/12", mem_req_o, req_ready_o, mem_addr_o); end
    step();
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b1;
    step();
    checks++; if (rsp_valid_o !== 4'b0010) begin errors++; $display("[TB] FAIL full_rsp1 got %b expected 0010", rsp_valid_o); end
    step();
    mem_valid_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0100) begin errors++; $display("[TB] FAIL full_rsp2 got %b expected 0100", rsp_valid_o); end
  endtask

  task automatic test_push_pop();
    doReset();
    req_valid_i = 4'b0001;
    mem_ready_i = 1'b1;
    step();
    req_valid_i = 4'b0010;
    mem_valid_i = 1'b1;
    mem_data_i  = 64'hAAAA_0000;
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL pp_accept1 got %b expected 0010", req_ready_o); end
    step();
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    #1;
    checks++; if (dut.count_q !== 2'd1) begin errors++; $display("[TB] FAIL pp_count got %0d expected 1", dut.count_q); end
    checks++; if (rsp_valid_o !== 4'b0001 || rsp_data_o !== 64'hAAAA_0000) begin errors++; $display("[TB] FAIL pp_rsp0 got %b/%h expected 0001/aaaa0000", rsp_valid_o, rsp_data_o); end
    mem_valid_i = 1'b1;
    mem_data_i  = 64'hBBBB_0000;
    step();
    mem_valid_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0010 || rsp_data_o !== 64'hBBBB_0000) begin errors++; $display("[TB] FAIL pp_rsp1 got %b/%h expected 0010/bbbb0000", rsp_valid_o, rsp_data_o); end
  endtask

  task automatic test_reset_midflight();
    doReset();
    req_valid_i = 4'b0011;
    mem_ready_i = 1'b1;
    step();
    step();
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    #1;
    checks++; if (dut.count_q !== 2'd2) begin errors++; $display("[TB] FAIL mid_count got %0d expected 2", dut.count_q); end
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    #1;
    checks++; if (dut.rr_q !== 2'd0 || dut.busy_q !== 4'b0000 || dut.count_q !== 2'd0) begin errors++; $display("[TB] FAIL mid_cleared rr=%0d busy=%b count=%0d expected 0/0000/0", dut.rr_q, dut.busy_q, dut.count_q); end
    req_valid_i = 4'b1000;
    mem_ready_i = 1'b1;
    mem_valid_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("[TB] FAIL mid_grant3 got %b expected 1000", req_ready_o); end
    step();
    req_valid_i = '0;
    mem_ready_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("[TB] FAIL mid_dropped got %b expected 0000", rsp_valid_o); end
    step();
    mem_valid_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 4'b1000) begin errors++; $display("[TB] FAIL mid_rsp3 got %b expected 1000", rsp_valid_o); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_lock();
    test_full_fifo();
    test_push_pop();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
